mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sequences a single shared memory-bus port between two requesters: the instruction-fetch path and the data load/store path.
- Issues one bus transaction at a time and waits for completion using the bus busy flag.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Drives a pipeline freeze while any request is outstanding.
- Sits between the fetch/memory stages and the bus manager.

Parameters:
- ADDR_W, 32, width of address ports.
- DATA_W, 32, width of data ports.
- TIMEOUT, 255, maximum WAIT cycles with busy_o high before abort (1..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_req  input  1  fetch request, held high until if_ack
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction, valid with if_ack
- if_ack  output  1  one-cycle fetch completion pulse
- dm_read  input  1  data load request, held until dm_ack
- dm_write  input  1  data store request, held until dm_ack
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_sel  input  4  store/load byte enables
- dm_rdata  output  DATA_W  load data, valid with dm_ack
- dm_ack  output  1  one-cycle data completion pulse
- err  output  1  pulses with the ack of a timed-out transaction
- freeze  output  1  pipeline stall
- read_i  output  1  bus read strobe
- write_i  output  1  bus write strobe
- adr_i  output  ADDR_W  bus address
- cpu_dat_i  output  DATA_W  bus write data
- sel_i  output  4  bus byte select
- cpu_dat_o  input  DATA_W  bus read data
- busy_o  input  1  bus busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: all outputs are 0, state is IDLE, last_grant = DATA, timeout counter = 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: grant only when busy_o = 0 and at least one request is present.
  - Both fetch and data requesting: grant the requester other than last_grant (round-robin).
  - Otherwise grant the single requester.
  - On grant, latch address, wdata, sel and op into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - read_i or write_i = 1.
  - adr_i = latched address.
  - sel_i = 4'hF for fetch, latched dm_sel for data.
  - cpu_dat_i = latched wdata for writes, 0 otherwise.
  - Next state is WAIT.
- Bus outputs outside ISSUE: read_i and write_i are 0. adr_i, sel_i and cpu_dat_i hold their last values.
- WAIT:
  - Completion is the first WAIT cycle with busy_o = 0. On that edge capture cpu_dat_o, update last_grant, go to IDLE.
  - A zero-wait bus completes in the first WAIT cycle.
- Ack timing:
  - The ack for the granted requester pulses for 1 cycle in the cycle after completion.
  - The matching rdata register holds the captured data from the ack cycle until the next ack of that requester.
  - Write acks leave dm_rdata unchanged.
- Latency: for a zero-wait bus, grant (IDLE) to ack is 3 cycles. An ack cannot coincide with a new grant of the same requester.
- Timeout:
  - The counter increments each WAIT cycle with busy_o = 1.
  - At count = TIMEOUT, abort to IDLE. The ack pulses next cycle with err = 1 and rdata = 0.
  - The counter clears on leaving WAIT.
- dm_read and dm_write both high: treated as a write; dm_read is ignored.
- A request dropped during ISSUE or WAIT: the transaction still completes and the ack is still pulsed.
- Requests are sampled only in IDLE. Inputs changing after the grant do not affect the transaction in flight.
- freeze = (if_req | dm_read | dm_write) & ~(ack for that requester this cycle), combinational.
- Reset mid-transaction: return to IDLE immediately and suppress any ack. No new issue occurs until busy_o = 0, because of the IDLE guard.
- Address is passed through unmodified. Alignment is the requester's responsibility.

Test Plan:
1. Fetch only, zero-wait bus: if_req = 1, if_addr = 0x10, cpu_dat_o = 0x00500093 -> read_i high 1 cycle with adr_i = 0x10, sel_i = F; if_ack 3 cycles after grant; if_rdata = 0x00500093.
2. Store with 4 busy cycles: dm_write = 1, dm_addr = 0x40, dm_wdata = 0xDEADBEEF, dm_sel = 0x3 -> write_i 1 cycle, cpu_dat_i = 0xDEADBEEF, sel_i = 3; dm_ack the cycle after busy_o falls; freeze high throughout until the ack.
3. Simultaneous fetch and load, back-to-back: first grant goes to fetch (last_grant = DATA after reset), then data, then fetch again. Verify the strobe order and that each ack carries the correct data.
4. Timeout: TIMEOUT = 8, busy_o stuck at 1 -> abort after 8 WAIT cycles; dm_ack = 1 and err = 1 together; dm_rdata = 0; the next request is not issued while busy_o = 1.
5. Reset during WAIT, then busy_o stays high 3 more cycles -> outputs are 0, no ack, no strobe until busy_o = 0; then the held if_req is issued.
6. dm_read and dm_write both high with addr 0x80 -> write_i only; dm_rdata is unchanged at the ack.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Request/acknowledge signals of the fetch and data paths plus the bus-manager port,
// bundled for the two-requester memory-bus arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_sel;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              err;
    logic              freeze;
    logic              read_i;
    logic              write_i;
    logic [ADDR_W-1:0] adr_i;
    logic [DATA_W-1:0] cpu_dat_i;
    logic [3:0]        sel_i;
    logic [DATA_W-1:0] cpu_dat_o;
    logic              busy_o;

    // The arbiter serves the requesters and drives the bus manager's strobes.
    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_sel,
               cpu_dat_o, busy_o,
        output if_rdata, if_ack, dm_rdata, dm_ack, err, freeze,
               read_i, write_i, adr_i, cpu_dat_i, sel_i
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_sel,
               cpu_dat_o, busy_o,
        input  if_rdata, if_ack, dm_rdata, dm_ack, err, freeze,
               read_i, write_i, adr_i, cpu_dat_i, sel_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory-bus port between instruction fetch and data load/store:
// round-robin grant, single-cycle issue, wait on busy with timeout, one-cycle ack.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    grant_e            lastGrant_q, lastGrant_d;
    grant_e            owner_q, owner_d;
    logic              isWrite_q, isWrite_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [3:0]        sel_q, sel_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              ifAck_q, ifAck_d;
    logic              dmAck_q, dmAck_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] dmRdata_q, dmRdata_d;

    logic dmReq;
    logic ifReqLive;
    logic dmReqLive;
    logic grantFetch;
    logic doGrant;
    logic complete;
    logic abort;
    logic finish;

    assign dmReq = bus_io.dm_read | bus_io.dm_write;

    // A requester still holds its request during its own ack cycle; masking it keeps
    // that stale request from being granted a second time.
    assign ifReqLive  = bus_io.if_req & ~ifAck_q;
    assign dmReqLive  = dmReq & ~dmAck_q;
    assign grantFetch = (ifReqLive & dmReqLive) ? (lastGrant_q == GRANT_DATA) : ifReqLive;
    assign doGrant    = (state_q == IDLE) & ~bus_io.busy_o & (ifReqLive | dmReqLive);
    assign complete   = (state_q == WAIT) & ~bus_io.busy_o;
    assign abort      = (state_q == WAIT) & bus_io.busy_o & (tmo_q == TMO_LAST);
    assign finish     = complete | abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_DATA;
            owner_q     <= GRANT_FETCH;
            isWrite_q   <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            sel_q       <= '0;
            tmo_q       <= '0;
            ifAck_q     <= 1'b0;
            dmAck_q     <= 1'b0;
            err_q       <= 1'b0;
            ifRdata_q   <= '0;
            dmRdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            isWrite_q   <= isWrite_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            sel_q       <= sel_d;
            tmo_q       <= tmo_d;
            ifAck_q     <= ifAck_d;
            dmAck_q     <= dmAck_d;
            err_q       <= err_d;
            ifRdata_q   <= ifRdata_d;
            dmRdata_q   <= dmRdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (doGrant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bus address/select/data registers are loaded at grant so they present the
    // transaction during ISSUE and simply hold their value afterwards.
    always_comb begin
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        isWrite_d   = isWrite_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        sel_d       = sel_q;
        tmo_d       = '0;
        ifAck_d     = 1'b0;
        dmAck_d     = 1'b0;
        err_d       = 1'b0;
        ifRdata_d   = ifRdata_q;
        dmRdata_d   = dmRdata_q;

        if (doGrant) begin
            owner_d   = grantFetch ? GRANT_FETCH : GRANT_DATA;
            isWrite_d = ~grantFetch & bus_io.dm_write;
            adr_d     = grantFetch ? bus_io.if_addr : bus_io.dm_addr;
            sel_d     = grantFetch ? 4'hF : bus_io.dm_sel;
            wdat_d    = (~grantFetch & bus_io.dm_write) ? bus_io.dm_wdata : '0;
        end

        if ((state_q == WAIT) && bus_io.busy_o && !abort) begin
            tmo_d = tmo_q + 8'd1;
        end

        if (finish) begin
            lastGrant_d = owner_q;
            err_d       = abort;
            if (owner_q == GRANT_FETCH) begin
                ifAck_d   = 1'b1;
                ifRdata_d = abort ? '0 : bus_io.cpu_dat_o;
            end else begin
                dmAck_d = 1'b1;
                if (!isWrite_q) begin
                    dmRdata_d = abort ? '0 : bus_io.cpu_dat_o;
                end
            end
        end
    end

    assign bus_io.read_i    = (state_q == ISSUE) & ~isWrite_q;
    assign bus_io.write_i   = (state_q == ISSUE) & isWrite_q;
    assign bus_io.adr_i     = adr_q;
    assign bus_io.sel_i     = sel_q;
    assign bus_io.cpu_dat_i = wdat_q;
    assign bus_io.if_ack    = ifAck_q;
    assign bus_io.dm_ack    = dmAck_q;
    assign bus_io.err       = err_q;
    assign bus_io.if_rdata  = ifRdata_q;
    assign bus_io.dm_rdata  = dmRdata_q;
    assign bus_io.freeze    = ~rst & ((bus_io.if_req & ~ifAck_q) | (dmReq & ~dmAck_q));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a busy-programmable bus responder, strobe and
// ack monitors, and one task per scenario comparing against bench-computed values.
module tb_mem_bus_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        bit          isFetch;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        bit          isFetch;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } ack_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          cyc;
    } strobe_t;

    logic clk;
    logic rst;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    exp_t        expQ[$];
    ack_t        ackLog[$];
    strobe_t     strobeLog[$];
    int          checks     = 0;
    int          failures   = 0;
    int          cycle      = 0;
    int          busyCycles = 0;
    int          busyRemain = 0;
    logic [31:0] lastDmRead = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Bus manager model: answers each strobe with memModel data and keeps busy high
    // for busyCycles WAIT cycles after the issue cycle.
    always @(negedge clk) begin
        if (bus.read_i || bus.write_i) begin
            busyRemain    = busyCycles;
            bus.cpu_dat_o = memModel(bus.adr_i);
        end else begin
            bus.busy_o = (busyRemain > 0);
            if (busyRemain > 0) busyRemain--;
        end
    end

    always @(negedge clk) begin
        if (bus.read_i || bus.write_i)
            strobeLog.push_back('{bus.read_i, bus.write_i, bus.adr_i, bus.sel_i, bus.cpu_dat_i, cycle});
        if (bus.if_ack) ackLog.push_back('{1'b1, bus.if_rdata, bus.err, cycle});
        if (bus.dm_ack) ackLog.push_back('{1'b0, bus.dm_rdata, bus.err, cycle});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clearLogs();
        expQ.delete();
        ackLog.delete();
        strobeLog.delete();
    endtask

    task automatic waitAcks(input int n, input int budget, output bit ok);
        int k = 0;
        while (ackLog.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (ackLog.size() >= n);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        repeat (3) tick();
        checks++;
        if ({bus.read_i, bus.write_i, bus.if_ack, bus.dm_ack, bus.err, bus.freeze} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got rd/wr/ifack/dmack/err/frz=%b, want 000000",
                     {bus.read_i, bus.write_i, bus.if_ack, bus.dm_ack, bus.err, bus.freeze});
        end
        checks++;
        if (bus.adr_i !== '0 || bus.sel_i !== '0 || bus.cpu_dat_i !== '0 ||
            bus.if_rdata !== '0 || bus.dm_rdata !== '0 || strobeLog.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_data: got adr=%h sel=%h wdat=%h ifr=%h dmr=%h strobes=%0d, want all 0",
                     bus.adr_i, bus.sel_i, bus.cpu_dat_i, bus.if_rdata, bus.dm_rdata, strobeLog.size());
        end
        bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bit ok;
        clearLogs();
        busyCycles  = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        expQ.push_back('{1'b1, memModel(32'h10), 1'b0});
        waitAcks(1, 20, ok);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || strobeLog.size() != 1) begin
            failures++;
            $display("[TB] FAIL fetch_done: got acks=%0d strobes=%0d, want 1 and 1", ackLog.size(), strobeLog.size());
        end else begin
            checks++;
            if (strobeLog[0].rd !== 1'b1 || strobeLog[0].wr !== 1'b0 || strobeLog[0].adr !== 32'h10 ||
                strobeLog[0].sel !== 4'hF || strobeLog[0].wdat !== 32'h0) begin
                failures++;
                $display("[TB] FAIL fetch_strobe: got rd=%b wr=%b adr=%h sel=%h wdat=%h, want 1 0 00000010 f 00000000",
                         strobeLog[0].rd, strobeLog[0].wr, strobeLog[0].adr, strobeLog[0].sel, strobeLog[0].wdat);
            end
            checks++;
            if (ackLog[0].cyc - strobeLog[0].cyc != 2) begin
                failures++;
                $display("[TB] FAIL fetch_latency: got issue-to-ack %0d, want 2", ackLog[0].cyc - strobeLog[0].cyc);
            end
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL fetch_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    task automatic test_store();
        bit seen      = 0;
        int freezeBad = 0;
        logic ackFreeze = 1'b1;
        clearLogs();
        busyCycles   = 4;
        bus.dm_write = 1'b1;
        bus.dm_addr  = 32'h40;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_sel   = 4'h3;
        expQ.push_back('{1'b0, lastDmRead, 1'b0});
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (bus.dm_ack) begin
                seen      = 1;
                ackFreeze = bus.freeze;
            end else if (bus.freeze !== 1'b1) begin
                freezeBad++;
            end
        end
        bus.dm_write = 1'b0;
        checks++;
        if (!seen || freezeBad != 0 || ackFreeze !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_freeze: got ack=%0b lowCycles=%0d ackFreeze=%b, want 1 0 0", seen, freezeBad, ackFreeze);
        end
        checks++;
        if (strobeLog.size() != 1 || ackLog.size() != 1) begin
            failures++;
            $display("[TB] FAIL store_count: got strobes=%0d acks=%0d, want 1 1", strobeLog.size(), ackLog.size());
        end else begin
            checks++;
            if (strobeLog[0].rd !== 1'b0 || strobeLog[0].wr !== 1'b1 || strobeLog[0].adr !== 32'h40 ||
                strobeLog[0].sel !== 4'h3 || strobeLog[0].wdat !== 32'hDEAD_BEEF) begin
                failures++;
                $display("[TB] FAIL store_strobe: got rd=%b wr=%b adr=%h sel=%h wdat=%h, want 0 1 00000040 3 deadbeef",
                         strobeLog[0].rd, strobeLog[0].wr, strobeLog[0].adr, strobeLog[0].sel, strobeLog[0].wdat);
            end
            checks++;
            if (ackLog[0].cyc - strobeLog[0].cyc != 6) begin
                failures++;
                $display("[TB] FAIL store_latency: got issue-to-ack %0d, want 6", ackLog[0].cyc - strobeLog[0].cyc);
            end
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL store_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int fetchAcks = 0;
        bit dataDone  = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lastDmRead = '0;
        clearLogs();
        busyCycles  = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h200;
        bus.dm_sel  = 4'hC;
        expQ.push_back('{1'b1, memModel(32'h100), 1'b0});
        expQ.push_back('{1'b0, memModel(32'h200), 1'b0});
        for (int k = 0; k < 40 && !(fetchAcks == 2 && dataDone); k++) begin
            tick();
            if (bus.if_ack) begin
                fetchAcks++;
                if (fetchAcks == 1) begin
                    bus.if_addr = 32'h104;
                    expQ.push_back('{1'b1, memModel(32'h104), 1'b0});
                end else begin
                    bus.if_req = 1'b0;
                end
            end
            if (bus.dm_ack) begin
                bus.dm_read = 1'b0;
                dataDone    = 1;
                lastDmRead  = memModel(32'h200);
            end
        end
        bus.if_req  = 1'b0;
        bus.dm_read = 1'b0;
        checks++;
        if (strobeLog.size() != 3 || ackLog.size() != 3) begin
            failures++;
            $display("[TB] FAIL b2b_count: got strobes=%0d acks=%0d, want 3 3", strobeLog.size(), ackLog.size());
        end else begin
            checks++;
            if (strobeLog[0].rd !== 1'b1 || strobeLog[0].adr !== 32'h100 || strobeLog[0].sel !== 4'hF ||
                strobeLog[1].rd !== 1'b1 || strobeLog[1].adr !== 32'h200 || strobeLog[1].sel !== 4'hC ||
                strobeLog[2].rd !== 1'b1 || strobeLog[2].adr !== 32'h104 || strobeLog[2].sel !== 4'hF) begin
                failures++;
                $display("[TB] FAIL b2b_order: got %h/%h %h/%h %h/%h, want 00000100/f 00000200/c 00000104/f",
                         strobeLog[0].adr, strobeLog[0].sel, strobeLog[1].adr, strobeLog[1].sel,
                         strobeLog[2].adr, strobeLog[2].sel);
            end
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL b2b_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int latency = -1;
        clearLogs();
        busyCycles  = 200;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h44;
        bus.dm_sel  = 4'hF;
        expQ.push_back('{1'b0, 32'h0, 1'b1});
        waitAcks(1, 40, ok);
        bus.dm_read = 1'b0;
        lastDmRead  = '0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h30;
        if (ok && strobeLog.size() > 0) latency = ackLog[0].cyc - strobeLog[0].cyc;
        checks++;
        if (!ok || latency != TIMEOUT + 1) begin
            failures++;
            $display("[TB] FAIL timeout_latency: got ack=%0b issue-to-ack %0d, want 1 %0d", ok, latency, TIMEOUT + 1);
        end
        repeat (10) tick();
        checks++;
        if (strobeLog.size() != 1) begin
            failures++;
            $display("[TB] FAIL timeout_busy_guard: got strobes=%0d while busy, want 1", strobeLog.size());
        end
        busyCycles = 0;
        busyRemain = 0;
        expQ.push_back('{1'b1, memModel(32'h30), 1'b0});
        waitAcks(2, 20, ok);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || strobeLog.size() != 2 || strobeLog[strobeLog.size()-1].adr !== 32'h30) begin
            failures++;
            $display("[TB] FAIL timeout_next: got acks=%0d strobes=%0d, want 2 2 with adr 00000030",
                     ackLog.size(), strobeLog.size());
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL timeout_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clearLogs();
        busyCycles  = 50;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        expQ.push_back('{1'b1, memModel(32'h20), 1'b0});
        for (int k = 0; k < 10 && strobeLog.size() == 0; k++) tick();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.read_i, bus.write_i, bus.if_ack, bus.dm_ack, bus.err, bus.freeze} !== 6'b0 ||
            bus.adr_i !== '0 || bus.sel_i !== '0 || bus.cpu_dat_i !== '0 || bus.if_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got ctrl=%b adr=%h sel=%h wdat=%h ifr=%h, want all 0",
                     {bus.read_i, bus.write_i, bus.if_ack, bus.dm_ack, bus.err, bus.freeze},
                     bus.adr_i, bus.sel_i, bus.cpu_dat_i, bus.if_rdata);
        end
        rst        = 1'b0;
        lastDmRead = '0;
        busyCycles = 0;
        busyRemain = 3;
        repeat (3) tick();
        checks++;
        if (strobeLog.size() != 1 || ackLog.size() != 0) begin
            failures++;
            $display("[TB] FAIL midreset_quiet: got strobes=%0d acks=%0d, want 1 0", strobeLog.size(), ackLog.size());
        end
        waitAcks(1, 20, ok);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || strobeLog.size() != 2 || strobeLog[strobeLog.size()-1].adr !== 32'h20) begin
            failures++;
            $display("[TB] FAIL midreset_reissue: got acks=%0d strobes=%0d, want 1 2 with adr 00000020",
                     ackLog.size(), strobeLog.size());
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL midreset_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    task automatic test_read_write_both();
        bit ok;
        clearLogs();
        busyCycles  = 1;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h84;
        bus.dm_sel  = 4'hF;
        expQ.push_back('{1'b0, memModel(32'h84), 1'b0});
        waitAcks(1, 20, ok);
        bus.dm_read = 1'b0;
        lastDmRead  = memModel(32'h84);
        tick();
        bus.dm_read  = 1'b1;
        bus.dm_write = 1'b1;
        bus.dm_addr  = 32'h80;
        bus.dm_wdata = 32'h1234_5678;
        bus.dm_sel   = 4'h5;
        expQ.push_back('{1'b0, lastDmRead, 1'b0});
        waitAcks(2, 20, ok);
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        checks++;
        if (!ok || strobeLog.size() != 2) begin
            failures++;
            $display("[TB] FAIL rw_count: got acks=%0d strobes=%0d, want 2 2", ackLog.size(), strobeLog.size());
        end else begin
            checks++;
            if (strobeLog[1].rd !== 1'b0 || strobeLog[1].wr !== 1'b1 || strobeLog[1].adr !== 32'h80 ||
                strobeLog[1].sel !== 4'h5 || strobeLog[1].wdat !== 32'h1234_5678) begin
                failures++;
                $display("[TB] FAIL rw_strobe: got rd=%b wr=%b adr=%h sel=%h wdat=%h, want 0 1 00000080 5 12345678",
                         strobeLog[1].rd, strobeLog[1].wr, strobeLog[1].adr, strobeLog[1].sel, strobeLog[1].wdat);
            end
        end
        while (expQ.size() > 0 && ackLog.size() > 0) begin
            exp_t e;
            ack_t o;
            e = expQ.pop_front();
            o = ackLog.pop_front();
            checks++;
            if (o.isFetch !== e.isFetch || o.data !== e.data || o.err !== e.err) begin
                failures++;
                $display("[TB] FAIL rw_ack: got f=%b d=%h e=%b, want f=%b d=%h e=%b",
                         o.isFetch, o.data, o.err, e.isFetch, e.data, e.err);
            end
        end
        tick();
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_read   = 1'b0;
        bus.dm_write  = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_sel    = '0;
        bus.cpu_dat_o = '0;
        bus.busy_o    = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_read_write_both();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
